audio_playback_scheduler: RTL and testbench

//   Buffers stereo samples written by the CPU over the IO bus and releases one L/R pair
//   per audio frame to the codec datapath. Frames are timed by the codec DAC LR clock.

---
 rtl/audio_playback_scheduler.sv | 209 ++++++++++++++++++++
 tb/tb_audio_playback_scheduler.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_playback_scheduler.sv
// rtl/audio_playback_scheduler.sv - stereo sample FIFO released one pair per codec frame, mixed with synth
//
// Purpose:
//   The CPU pushes packed {L,R} stereo pairs over the IO bus. Once enabled and primed
//   to the low-water level, one pair is popped per codec DAC LR clock frame, summed
//   with the synthesizer samples and presented to the audio converter. A level
//   interrupt requests a refill when the FIFO runs low.
//
// Optional feature macro:
//   AUDIO_SCHED_SAT_EN  - defined: signed saturating mix; undefined: 16-bit wrap-around add
//
// Ports:
//   iCLK          in   1   system clock, posedge
//   iRST_N        in   1   asynchronous active-low reset
//   iAUD_DACLRCK  in   1   codec DAC LR clock (asynchronous), falling edge marks a frame
//   wReadEnable   in   1   bus read strobe
//   wWriteEnable  in   1   bus write strobe
//   wAddress      in   32  bus address (DATA=BASE+0, STATUS=BASE+4, CTRL=BASE+8)
//   wWriteData    in   32  bus write data
//   wReadData     out  32  bus read data, high-impedance when not addressed
//   iSynthL/R     in   16  synthesizer samples, two's complement
//   oAudioL/R     out  16  mixed samples to the converter
//   oIrq          out  1   registered refill interrupt
`timescale 1ns/1ps

module audio_playback_scheduler #(
  parameter int          DEPTH_LOG2 = 4,
  parameter int          LOW_WATER  = 4,
  parameter logic [31:0] BASE_ADDR  = 32'hFF000200
) (
  input  logic        iCLK,
  input  logic        iRST_N,
  input  logic        iAUD_DACLRCK,
  input  logic        wReadEnable,
  input  logic        wWriteEnable,
  input  logic [31:0] wAddress,
  input  logic [31:0] wWriteData,
  output logic [31:0] wReadData,
  input  logic [15:0] iSynthL,
  input  logic [15:0] iSynthR,
  output logic [15:0] oAudioL,
  output logic [15:0] oAudioR,
  output logic        oIrq
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;

  typedef enum logic [1:0] {S_IDLE, S_PRIME, S_RUN} state_t;

  state_t                state;
  logic [31:0]           mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [CW-1:0]         count;
  logic                  en;
  logic                  irq_en;
  logic                  unf;
  logic                  ovf;
  // [0],[1]: two-stage synchronizer; [2]: previous synchronized level for edge detect
  logic [2:0]            lrck_sync;

  logic        tick;
  logic        hit_data;
  logic        hit_status;
  logic        hit_ctrl;
  logic        ctrl_wr;
  logic        push_req;
  logic        flush;
  logic        full;
  logic        empty;
  logic        irq;
  logic        do_push;
  logic        pop;
  logic        underrun;
  logic [31:0] rd_val;
  logic [31:0] head;

  function automatic logic [15:0] mix(input logic [15:0] a, input logic [15:0] b);
`ifdef AUDIO_SCHED_SAT_EN
    logic [16:0] s;
    s = {a[15], a} + {b[15], b};
    // Sign bits disagree only when the true sum left the 16-bit range.
    if (s[16] != s[15]) mix = s[16] ? 16'h8000 : 16'h7FFF;
    else                mix = s[15:0];
`else
    mix = a + b;
`endif
  endfunction

  assign hit_data   = (wAddress == BASE_ADDR);
  assign hit_status = (wAddress == BASE_ADDR + 32'd4);
  assign hit_ctrl   = (wAddress == BASE_ADDR + 32'd8);
  assign ctrl_wr    = wWriteEnable && hit_ctrl;
  assign push_req   = wWriteEnable && hit_data;

  assign tick  = lrck_sync[2] & ~lrck_sync[1];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign irq   = irq_en && (state == S_RUN) && (count < CW'(LOW_WATER));
  assign head  = mem[rd_ptr];

  // The FIFO is held empty while idle and already in the cycle en drops.
  assign flush    = (state == S_IDLE) || !en;
  assign do_push  = push_req && !full && !flush;
  assign pop      = en && (state == S_RUN) && tick && !empty;
  assign underrun = en && (state == S_RUN) && tick && empty;

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) lrck_sync <= 3'b000;
    else         lrck_sync <= {lrck_sync[1:0], iAUD_DACLRCK};
  end

  always_ff @(posedge iCLK) begin
    if (do_push) mem[wr_ptr] <= wWriteData;
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      en     <= 1'b0;
      irq_en <= 1'b0;
      unf    <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      if (ctrl_wr) begin
        en     <= wWriteData[0];
        irq_en <= wWriteData[1];
      end
      // A new event wins over a clear arriving in the same cycle.
      if (underrun)                     unf <= 1'b1;
      else if (ctrl_wr && wWriteData[2]) unf <= 1'b0;
      if (push_req && full && !flush)   ovf <= 1'b1;
      else if (ctrl_wr && wWriteData[3]) ovf <= 1'b0;
    end
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state   <= S_IDLE;
      oAudioL <= '0;
      oAudioR <= '0;
      oIrq    <= 1'b0;
    end else begin
      oIrq <= irq;
      if (!en) begin
        state   <= S_IDLE;
        oAudioL <= '0;
        oAudioR <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            state   <= S_PRIME;
            oAudioL <= '0;
            oAudioR <= '0;
          end
          S_PRIME: begin
            oAudioL <= '0;
            oAudioR <= '0;
            if (count >= CW'(LOW_WATER)) state <= S_RUN;
          end
          S_RUN: begin
            if (pop) begin
              oAudioL <= mix(head[31:16], iSynthL);
              oAudioR <= mix(head[15:0],  iSynthR);
            end else if (underrun) begin
              oAudioL <= '0;
              oAudioR <= '0;
              state   <= S_PRIME;
            end
          end
          default: begin
            state   <= S_IDLE;
            oAudioL <= '0;
            oAudioR <= '0;
          end
        endcase
      end
    end
  end

  always_comb begin
    rd_val = '0;
    if (hit_status)    rd_val = {16'b0, 8'(count), 3'b0, ovf, unf, irq, full, empty};
    else if (hit_ctrl) rd_val = {30'b0, irq_en, en};
  end

  assign wReadData = (wReadEnable && (hit_data || hit_status || hit_ctrl)) ? rd_val : 32'hzzzz_zzzz;

endmodule

// File: tb/tb_audio_playback_scheduler.sv
// tb/tb_audio_playback_scheduler.sv - self-checking bench for audio_playback_scheduler
`timescale 1ns/1ps

module tb_audio_playback_scheduler;

  localparam logic [31:0] A_DATA   = 32'hFF000200;
  localparam logic [31:0] A_STATUS = 32'hFF000204;
  localparam logic [31:0] A_CTRL   = 32'hFF000208;
`ifdef AUDIO_SCHED_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic        iCLK = 1'b0;
  logic        iRST_N;
  logic        iAUD_DACLRCK;
  logic        wReadEnable;
  logic        wWriteEnable;
  logic [31:0] wAddress;
  logic [31:0] wWriteData;
  wire  [31:0] wReadData;
  logic [15:0] iSynthL;
  logic [15:0] iSynthR;
  logic [15:0] oAudioL;
  logic [15:0] oAudioR;
  logic        oIrq;

  int checks   = 0;
  int failures = 0;

  audio_playback_scheduler dut (
    .iCLK         (iCLK),
    .iRST_N       (iRST_N),
    .iAUD_DACLRCK (iAUD_DACLRCK),
    .wReadEnable  (wReadEnable),
    .wWriteEnable (wWriteEnable),
    .wAddress     (wAddress),
    .wWriteData   (wWriteData),
    .wReadData    (wReadData),
    .iSynthL      (iSynthL),
    .iSynthR      (iSynthR),
    .oAudioL      (oAudioL),
    .oAudioR      (oAudioR),
    .oIrq         (oIrq)
  );

  always #5 iCLK = ~iCLK;

  typedef struct {
    logic [15:0] l, r, sl, sr;
    logic [15:0] wrap_l, wrap_r, sat_l, sat_r;
  } mix_vec_t;

  mix_vec_t vecs[6];

  // Reference model state
  logic [31:0] q[$];
  bit          m_running, m_unf, m_ovf, m_irq_en;
  logic [15:0] m_out_l, m_out_r;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge iCLK);
    wWriteEnable = 1'b1; wAddress = a; wWriteData = d;
    @(negedge iCLK);
    wWriteEnable = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    @(negedge iCLK);
    wReadEnable = 1'b1; wAddress = a;
    #1 d = wReadData;
    wReadEnable = 1'b0;
  endtask

  task automatic frame_tick();
    @(negedge iCLK);
    iAUD_DACLRCK = 1'b1;
    repeat (4) @(negedge iCLK);
    iAUD_DACLRCK = 1'b0;
    repeat (5) @(negedge iCLK);
  endtask

  task automatic do_reset();
    @(negedge iCLK);
    iRST_N = 1'b0; wReadEnable = 1'b0; wWriteEnable = 1'b0;
    wAddress = '0; wWriteData = '0; iAUD_DACLRCK = 1'b0;
    iSynthL = '0; iSynthR = '0;
    repeat (2) @(negedge iCLK);
    iRST_N = 1'b1;
    @(negedge iCLK);
  endtask

  function automatic logic [15:0] ref_mix(input logic [15:0] a, input logic [15:0] b);
    int s;
    logic [31:0] v;
    s = int'($signed(a)) + int'($signed(b));
    if (SAT) begin
      if (s > 32767)  s = 32767;
      if (s < -32768) s = -32768;
    end
    v = s;
    return v[15:0];
  endfunction

  function automatic logic [31:0] model_status();
    logic [7:0] c;
    bit irq;
    c = 8'(q.size());
    irq = m_irq_en && m_running && (q.size() < 4);
    return {16'b0, c, 3'b0, m_ovf, m_unf, irq, q.size() == 16, q.size() == 0};
  endfunction

  initial begin
    #3000000;
    $display("FAIL watchdog timeout actual=running expected=finished");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    int          found;

    vecs[0] = '{16'h7000, 16'h0001, 16'h2000, 16'h0002, 16'h9000, 16'h0003, 16'h7FFF, 16'h0003};
    vecs[1] = '{16'h8000, 16'h1234, 16'hFFFF, 16'h1111, 16'h7FFF, 16'h2345, 16'h8000, 16'h2345};
    vecs[2] = '{16'hFFFF, 16'h8001, 16'h0001, 16'h8001, 16'h0000, 16'h0002, 16'h0000, 16'h8000};
    vecs[3] = '{16'h4000, 16'h7FFF, 16'h3FFF, 16'h0001, 16'h7FFF, 16'h8000, 16'h7FFF, 16'h7FFF};
    vecs[4] = '{16'hC000, 16'h0000, 16'hC000, 16'h0000, 16'h8000, 16'h0000, 16'h8000, 16'h0000};
    vecs[5] = '{16'hA5A5, 16'h5A5A, 16'h0000, 16'hFFFF, 16'hA5A5, 16'h5A59, 16'hA5A5, 16'h5A59};

    iRST_N = 1'b0;
    do_reset();

    // Reset state
    check("reset_out_l", 32'(oAudioL), 32'h0);
    check("reset_out_r", 32'(oAudioR), 32'h0);
    check("reset_irq", 32'(oIrq), 32'h0);
    bus_read(A_STATUS, rd); check("reset_status", rd, 32'h0000_0001);
    bus_read(A_CTRL, rd);   check("reset_ctrl", rd, 32'h0);

    // Priming: 3 pairs keep outputs quiet, 4th starts playback
    bus_write(A_CTRL, 32'h1);
    repeat (2) @(negedge iCLK);
    for (int i = 0; i < 3; i++) bus_write(A_DATA, {16'h1110 + 16'(i), 16'h2220 + 16'(i)});
    iSynthL = 16'h1234; iSynthR = 16'h4321;
    for (int i = 0; i < 5; i++) begin
      frame_tick();
      check($sformatf("prime_out_l_%0d", i), 32'(oAudioL), 32'h0);
    end
    bus_read(A_STATUS, rd); check("prime_status", rd, 32'h0000_0300);
    bus_write(A_DATA, 32'h1113_2223);
    iSynthL = '0; iSynthR = '0;
    frame_tick();
    check("first_out_l", 32'(oAudioL), 32'h1110);
    check("first_out_r", 32'(oAudioR), 32'h2220);

    // Mix vectors, then underrun and PRIME re-entry
    do_reset();
    bus_write(A_CTRL, 32'h1);
    repeat (2) @(negedge iCLK);
    for (int i = 0; i < 6; i++) bus_write(A_DATA, {vecs[i].l, vecs[i].r});
    for (int i = 0; i < 6; i++) begin
      iSynthL = vecs[i].sl; iSynthR = vecs[i].sr;
      frame_tick();
      check($sformatf("mix_l_%0d", i), 32'(oAudioL), 32'(SAT ? vecs[i].sat_l : vecs[i].wrap_l));
      check($sformatf("mix_r_%0d", i), 32'(oAudioR), 32'(SAT ? vecs[i].sat_r : vecs[i].wrap_r));
    end
    frame_tick();
    check("unf_out_l", 32'(oAudioL), 32'h0);
    check("unf_out_r", 32'(oAudioR), 32'h0);
    bus_read(A_STATUS, rd); check("unf_status", rd, 32'h0000_0009);
    bus_write(A_CTRL, 32'h5);
    bus_read(A_STATUS, rd); check("unf_clear_status", rd, 32'h0000_0001);
    for (int i = 0; i < 3; i++) bus_write(A_DATA, 32'h5555_6666);
    iSynthL = 16'h0101;
    frame_tick();
    check("reprime_out_l", 32'(oAudioL), 32'h0);
    bus_read(A_STATUS, rd); check("reprime_status", rd, 32'h0000_0300);

    // Overfill: disabled flushes, enabled saturates at 16 with ovf
    do_reset();
    for (int i = 0; i < 17; i++) bus_write(A_DATA, 32'hABCD_0000 + i);
    bus_read(A_STATUS, rd); check("disabled_push_status", rd, 32'h0000_0001);
    bus_write(A_CTRL, 32'h1);
    repeat (2) @(negedge iCLK);
    for (int i = 0; i < 17; i++) bus_write(A_DATA, 32'hABCD_0000 + i);
    bus_read(A_STATUS, rd); check("overfill_status", rd, 32'h0000_1012);
    bus_write(A_CTRL, 32'h9);
    bus_read(A_STATUS, rd); check("ovf_clear_status", rd, 32'h0000_1002);
    bus_write(A_CTRL, 32'h0);
    repeat (2) @(negedge iCLK);
    bus_read(A_STATUS, rd); check("disable_flush_status", rd, 32'h0000_0001);

    // Low-water interrupt, tick latency, then async reset mid-run
    do_reset();
    bus_write(A_CTRL, 32'h3);
    repeat (2) @(negedge iCLK);
    for (int i = 0; i < 5; i++) bus_write(A_DATA, 32'h1000_2000 + 32'(i) * 32'h0001_0001);
    repeat (3) @(negedge iCLK);
    frame_tick();
    bus_read(A_STATUS, rd); check("lw_count4_status", rd, 32'h0000_0400);
    check("lw_irq_at4", 32'(oIrq), 32'h0);
    @(negedge iCLK);
    wReadEnable = 1'b1; wAddress = A_STATUS;
    iAUD_DACLRCK = 1'b1;
    repeat (4) @(negedge iCLK);
    iAUD_DACLRCK = 1'b0;
    found = -1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge iCLK);
      if (found >= 0 && c == found + 1) check("lw_irq_after", 32'(oIrq), 32'h1);
      if (found < 0 && wReadData[15:8] == 8'd3) begin
        found = c;
        check("lw_irq_same_cycle", 32'(oIrq), 32'h0);
      end
    end
    check("tick_latency", 32'(found), 32'd3);
    check("pre_reset_out_l", 32'(oAudioL), 32'h1001);
    #2 iRST_N = 1'b0;
    #1;
    check("async_rst_out_l", 32'(oAudioL), 32'h0);
    check("async_rst_out_r", 32'(oAudioR), 32'h0);
    check("async_rst_irq", 32'(oIrq), 32'h0);
    check("async_rst_status", wReadData, 32'h0000_0001);
    wReadEnable = 1'b0;
    @(negedge iCLK);
    iRST_N = 1'b1;

    // Randomized traffic against the queue model
    do_reset();
    q.delete();
    m_running = 0; m_unf = 0; m_ovf = 0; m_irq_en = 1; m_out_l = '0; m_out_r = '0;
    bus_write(A_CTRL, 32'h3);
    repeat (2) @(negedge iCLK);
    for (int n = 0; n < 200; n++) begin
      int op;
      op = $urandom_range(0, 99);
      if (op < 55) begin
        logic [31:0] d;
        d = $urandom;
        bus_write(A_DATA, d);
        if (q.size() == 16) m_ovf = 1;
        else q.push_back(d);
        if (!m_running && q.size() >= 4) m_running = 1;
      end else if (op < 92) begin
        iSynthL = 16'($urandom); iSynthR = 16'($urandom);
        frame_tick();
        if (m_running) begin
          if (q.size() > 0) begin
            logic [31:0] d;
            d = q.pop_front();
            m_out_l = ref_mix(d[31:16], iSynthL);
            m_out_r = ref_mix(d[15:0], iSynthR);
          end else begin
            m_unf = 1; m_running = 0; m_out_l = '0; m_out_r = '0;
          end
        end
        check($sformatf("rand_out_l_%0d", n), 32'(oAudioL), 32'(m_out_l));
        check($sformatf("rand_out_r_%0d", n), 32'(oAudioR), 32'(m_out_r));
      end else begin
        logic [3:0] c;
        c = 4'($urandom);
        c[0] = 1'b1;
        bus_write(A_CTRL, 32'(c));
        m_irq_en = c[1];
        if (c[2]) m_unf = 0;
        if (c[3]) m_ovf = 0;
      end
      repeat (3) @(negedge iCLK);
      bus_read(A_STATUS, rd);
      check($sformatf("rand_status_%0d", n), rd, model_status());
      check($sformatf("rand_irq_%0d", n), 32'(oIrq), 32'(model_status() >> 2 & 32'h1));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
